uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one UART transmit channel between NUM_REQ byte-stream requesters.
//  Sequences the channel's DATA/SEND input and BUSY/COMPLETE/ERROR flag handshake: grants one requester at a time,
//  issues its bytes one by one, and releases the grant at end of burst, at MAX_BURST, on error or on timeout.
//  Sits between the packet sources (status, debug, command-reply) and the single UART instance.
// PARAMETERS
//  NUM_REQ         4        number of requesters (2..8)
//  MAX_BURST       16       max bytes per grant before a forced release (1..255)
//  TIMEOUT_CYCLES  1048576  SYSCLK cycles to wait for UART_COMPLETE/UART_ERROR before abort (>=2)
// PORTS
//  SYSCLK         in   1          system clock, all logic on rising edge
//  RESET          in   1          asynchronous, active-high reset
//  REQ_VALID      in   NUM_REQ    requester i has a byte ready on REQ_DATA[8i+7:8i]
//  REQ_DATA       in   NUM_REQ*8  flattened byte bus, requester i at [8i+7:8i]
//  REQ_LAST       in   NUM_REQ    byte presented by requester i is the last of its burst
//  GRANT          out  NUM_REQ    one-hot owner of the channel, all-zero when idle
//  REQ_ACK        out  NUM_REQ    1-cycle pulse: byte taken, requester may present next
//  REQ_DONE       out  NUM_REQ    1-cycle pulse: taken byte completed on the line
//  REQ_ERR        out  NUM_REQ    1-cycle pulse: byte failed (UART_ERROR or timeout), burst aborted
//  UART_DATA      out  8          byte to UART, held stable from UART_SEND until completion
//  UART_SEND      out  1          1-cycle start pulse to UART
//  UART_BUSY      in   1          UART busy flag
//  UART_COMPLETE  in   1          UART completion flag (sampled level, acted on once per byte)
//  UART_ERROR     in   1          UART error flag
//  TIMEOUT_FLAG   out  1          sticky: a timeout has occurred; cleared only by RESET
// BEHAVIOUR
//  - All outputs registered. On RESET: GRANT=0, REQ_ACK/REQ_DONE/REQ_ERR=0, UART_DATA=8'h00, UART_SEND=0,
//    TIMEOUT_FLAG=0, state=IDLE, burst count=0, RR pointer=NUM_REQ-1 so requester 0 has first priority.
//  - RESET mid-operation: everything returns to the reset values at once; the in-flight byte gets no DONE or ERR.
//  - States: IDLE, ISSUE, WAIT.
//  - IDLE: if any REQ_VALID, pick the first requester with VALID=1 searching from pointer+1 with wrap.
//    Set GRANT one-hot, pointer=winner, burst count=0, go to ISSUE. Latency from VALID to GRANT is 1 cycle.
//  - ISSUE, granted requester g:
//      REQ_VALID[g]=0            -> GRANT=0, go to IDLE (source withdrew).
//      REQ_VALID[g]=1, BUSY=1    -> hold in ISSUE.
//      REQ_VALID[g]=1, BUSY=0    -> UART_DATA=REQ_DATA[g], UART_SEND=1, REQ_ACK[g]=1, latch REQ_LAST[g],
//                                   clear timeout counter, go to WAIT.
//    UART_SEND therefore rises 1 cycle after GRANT at the earliest.
//  - WAIT: ignore UART_COMPLETE/UART_ERROR in the first cycle after UART_SEND (UART flags not yet updated).
//    Then, in priority order:
//      UART_ERROR=1                     -> REQ_ERR[g]=1, GRANT=0, go to IDLE. Error wins over simultaneous COMPLETE.
//      UART_COMPLETE=1                  -> REQ_DONE[g]=1, burst count+1.
//                                          If latched LAST or new count==MAX_BURST: GRANT=0, go to IDLE.
//                                          Otherwise go to ISSUE with GRANT held.
//      counter==TIMEOUT_CYCLES-1        -> TIMEOUT_FLAG=1, REQ_ERR[g]=1, GRANT=0, go to IDLE.
//    Otherwise the counter increments, saturating.
//  - Forced release at MAX_BURST: the pointer has already advanced past g, so other waiting requesters are served first.
//    g re-arbitrates normally for the rest of its stream.
//  - Ordering of pulses: REQ_ACK/REQ_DONE/REQ_ERR are never asserted for a non-granted index;
//    at most one of them is high in any cycle.
//  - Burst count is 8 bits; MAX_BURST is compared for equality, so no wrap occurs.
// TESTING
//  1. REQ_VALID[2]=1, DATA=8'hA5, LAST=1, BUSY=0
//     -> GRANT=4'b0100 next cycle; UART_SEND pulse with UART_DATA=8'hA5 and REQ_ACK[2];
//        COMPLETE -> REQ_DONE[2], GRANT=0.
//  2. All four VALID and LAST held high, UART completes each byte after 10 cycles
//     -> grant order 0,1,2,3,0,1; no index repeats while others wait.
//  3. MAX_BURST=16; req1 streams 20 bytes (LAST on 20th), req3 VALID throughout
//     -> req1 released after 16th DONE; req3 served; then req1 sends its last 4 bytes.
//  4. UART_ERROR and UART_COMPLETE both high on 2nd byte of a 5-byte burst from req0
//     -> REQ_ERR[0] only, no REQ_DONE, GRANT=0, next winner is req1 if it is valid.
//  5. TIMEOUT_CYCLES=100, UART never completes
//     -> 100 cycles after SEND: TIMEOUT_FLAG=1 (stays 1), REQ_ERR[g] pulse, GRANT=0;
//        UART_BUSY=1 during ISSUE delays SEND until BUSY=0.
//  6. RESET asserted during WAIT
//     -> GRANT/UART_SEND/TIMEOUT_FLAG=0 asynchronously, no DONE;
//        after release with all VALID high, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler that shares one UART transmit channel
//               between NUM_REQ byte-stream requesters. It grants one owner at
//               a time, issues that owner's bytes over the DATA/SEND interface,
//               and tracks the BUSY/COMPLETE/ERROR handshake. It releases the
//               grant at end of burst, at MAX_BURST, on error or on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   SYSCLK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [NUM_REQ*8-1:0]   REQ_DATA,
    input  logic [NUM_REQ-1:0]     REQ_LAST,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [NUM_REQ-1:0]     REQ_ACK,
    output logic [NUM_REQ-1:0]     REQ_DONE,
    output logic [NUM_REQ-1:0]     REQ_ERR,
    output logic [7:0]             UART_DATA,
    output logic                   UART_SEND,
    input  logic                   UART_BUSY,
    input  logic                   UART_COMPLETE,
    input  logic                   UART_ERROR,
    output logic                   TIMEOUT_FLAG
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0]         c_ST_IDLE   = 2'd0;
    localparam logic [1:0]         c_ST_ISSUE  = 2'd1;
    localparam logic [1:0]         c_ST_WAIT   = 2'd2;

    // Pointer resets to the last index so requester 0 is searched first
    localparam logic [PTR_W-1:0]   c_PTR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]    c_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_BURST_MAX = 8'(MAX_BURST);
    localparam logic [NUM_REQ-1:0] c_ONE       = NUM_REQ'(1);

    // Control state
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [PTR_W-1:0]    r_ptr;        // last winner, doubles as current owner index
    logic [7:0]          r_burst;      // bytes completed in the current grant
    logic [TO_W-1:0]     r_cnt;        // cycles spent waiting for the UART
    logic                r_first;      // first WAIT cycle, UART flags still stale
    logic                r_last;       // latched LAST of the byte in flight

    // Registered outputs
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_err;
    logic [7:0]          r_uart_data;
    logic                r_uart_send;
    logic                r_tflag;

    // Arbitration
    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [PTR_W-1:0]    w_cand;

    // Per-cycle events decided by the next-state logic
    logic                w_take;       // new grant issued from IDLE
    logic                w_send;       // byte handed to the UART
    logic                w_done;       // byte completed
    logic                w_err;        // byte failed (error or timeout)
    logic                w_to;         // timeout expired
    logic                w_rel;        // grant dropped this cycle

    // Next values of the registered outputs
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic [NUM_REQ-1:0]  w_err_nxt;
    logic [7:0]          w_data_nxt;
    logic                w_send_nxt;
    logic                w_tflag_nxt;

    // Round-robin search: first valid requester after the pointer, with wrap
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && REQ_VALID[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // State register
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle event decode
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_send      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_to        = 1'b0;
        w_rel       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (!REQ_VALID[r_ptr]) begin
                    // Owner withdrew its stream
                    w_rel       = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (!UART_BUSY) begin
                    w_send      = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_first) begin
                    // UART flags do not yet reflect the byte just sent
                    w_state_nxt = c_ST_WAIT;
                end else if (UART_ERROR) begin
                    w_err       = 1'b1;
                    w_rel       = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (UART_COMPLETE) begin
                    w_done = 1'b1;
                    if (r_last || ((r_burst + 8'd1) == c_BURST_MAX)) begin
                        w_rel       = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_ISSUE;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_to        = 1'b1;
                    w_err       = 1'b1;
                    w_rel       = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: next values of every registered output
    always_comb begin
        w_grant_nxt = r_grant;
        if (w_take) begin
            w_grant_nxt = c_ONE << w_win;
        end else if (w_rel) begin
            w_grant_nxt = '0;
        end
        w_ack_nxt   = w_send ? (c_ONE << r_ptr) : '0;
        w_done_nxt  = w_done ? (c_ONE << r_ptr) : '0;
        w_err_nxt   = w_err  ? (c_ONE << r_ptr) : '0;
        w_data_nxt  = w_send ? REQ_DATA[{r_ptr, 3'b000} +: 8] : r_uart_data;
        w_send_nxt  = w_send;
        w_tflag_nxt = r_tflag | w_to;
    end

    // Output registers
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_grant     <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_uart_data <= 8'h00;
            r_uart_send <= 1'b0;
            r_tflag     <= 1'b0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_uart_data <= w_data_nxt;
            r_uart_send <= w_send_nxt;
            r_tflag     <= w_tflag_nxt;
        end
    end

    // Arbitration pointer, burst count, wait counter and per-byte flags
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_ptr   <= c_PTR_RESET;
            r_burst <= 8'd0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_take) begin
                r_ptr   <= w_win;
                r_burst <= 8'd0;
            end else if (w_done) begin
                r_burst <= r_burst + 8'd1;
            end

            if (w_send) begin
                r_cnt <= '0;
            end else if ((r_state == c_ST_WAIT) && (r_cnt != {TO_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_first <= w_send;
            if (w_send) begin
                r_last <= REQ_LAST[r_ptr];
            end
        end
    end

    assign GRANT        = r_grant;
    assign REQ_ACK      = r_ack;
    assign REQ_DONE     = r_done;
    assign REQ_ERR      = r_err;
    assign UART_DATA    = r_uart_data;
    assign UART_SEND    = r_uart_send;
    assign TIMEOUT_FLAG = r_tflag;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_scheduler
// Description : Directed self-checking bench for uart_tx_scheduler with
//               requester and UART behavioural models and a send/outcome
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;

    logic              SYSCLK = 1'b0;
    logic              RESET  = 1'b1;
    logic [NREQ-1:0]   REQ_VALID = '0;
    logic [NREQ*8-1:0] REQ_DATA  = '0;
    logic [NREQ-1:0]   REQ_LAST  = '0;
    logic [NREQ-1:0]   GRANT;
    logic [NREQ-1:0]   REQ_ACK;
    logic [NREQ-1:0]   REQ_DONE;
    logic [NREQ-1:0]   REQ_ERR;
    logic [7:0]        UART_DATA;
    logic              UART_SEND;
    wire               UART_BUSY;
    logic              UART_COMPLETE = 1'b0;
    logic              UART_ERROR    = 1'b0;
    logic              TIMEOUT_FLAG;

    uart_tx_scheduler #(
        .NUM_REQ        (NREQ),
        .MAX_BURST      (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RESET         (RESET),
        .REQ_VALID     (REQ_VALID),
        .REQ_DATA      (REQ_DATA),
        .REQ_LAST      (REQ_LAST),
        .GRANT         (GRANT),
        .REQ_ACK       (REQ_ACK),
        .REQ_DONE      (REQ_DONE),
        .REQ_ERR       (REQ_ERR),
        .UART_DATA     (UART_DATA),
        .UART_SEND     (UART_SEND),
        .UART_BUSY     (UART_BUSY),
        .UART_COMPLETE (UART_COMPLETE),
        .UART_ERROR    (UART_ERROR),
        .TIMEOUT_FLAG  (TIMEOUT_FLAG)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct { int idx; logic [7:0] data; } send_t;
    typedef struct { int idx; bit err; } out_t;
    typedef struct { int dly; int kind; } resp_t;   // kind: 0 ok, 1 err, 2 err+ok, 3 silent

    send_t exp_send[$];
    out_t  exp_out[$];
    resp_t resp_q[$];
    logic [7:0] rq_d[NREQ][$];
    bit         rq_l[NREQ][$];

    int  def_dly    = 10;
    bit  force_busy = 1'b0;
    bit  u_busy     = 1'b0;
    bit  u_act      = 1'b0;
    int  u_cnt      = 0;
    int  u_kind     = 0;

    assign UART_BUSY = u_busy | force_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic push_req(input int i, input logic [7:0] d, input bit l);
        rq_d[i].push_back(d);
        rq_l[i].push_back(l);
    endtask

    task automatic exp_byte(input int i, input logic [7:0] d, input bit err);
        send_t s;
        out_t  o;
        s.idx = i; s.data = d;
        o.idx = i; o.err = err;
        exp_send.push_back(s);
        exp_out.push_back(o);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (exp_send.size() == 0 && exp_out.size() == 0 && GRANT == '0 && !u_act &&
                rq_d[0].size() == 0 && rq_d[1].size() == 0 &&
                rq_d[2].size() == 0 && rq_d[3].size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({"drain_", tag}, 32'(ok), 32'd1);
    endtask

    task automatic wait_send(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (UART_SEND) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({"send_seen_", tag}, 32'(seen), 32'd1);
    endtask

    // Requester models: pop on ACK, present the head of each queue
    always @(negedge SYSCLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (REQ_ACK[i] && rq_d[i].size() > 0) begin
                void'(rq_d[i].pop_front());
                void'(rq_l[i].pop_front());
            end
            REQ_VALID[i]       = (rq_d[i].size() > 0);
            REQ_DATA[8*i +: 8] = (rq_d[i].size() > 0) ? rq_d[i][0] : 8'h00;
            REQ_LAST[i]        = (rq_l[i].size() > 0) ? rq_l[i][0] : 1'b0;
        end
    end

    // UART model: after SEND, raise the selected flag(s) for one cycle after dly cycles
    always @(negedge SYSCLK) begin
        resp_t r;
        UART_COMPLETE = 1'b0;
        UART_ERROR    = 1'b0;
        if (RESET) begin
            u_act  = 1'b0;
            u_busy = 1'b0;
        end else if (UART_SEND) begin
            if (resp_q.size() > 0) r = resp_q.pop_front();
            else begin r.dly = def_dly; r.kind = 0; end
            if (r.kind == 3) begin
                u_act  = 1'b0;
                u_busy = 1'b0;
            end else begin
                u_act  = 1'b1;
                u_busy = 1'b1;
                u_cnt  = r.dly;
                u_kind = r.kind;
            end
        end else if (u_act) begin
            u_cnt--;
            if (u_cnt <= 0) begin
                u_act         = 1'b0;
                u_busy        = 1'b0;
                UART_COMPLETE = (u_kind == 0) || (u_kind == 2);
                UART_ERROR    = (u_kind == 1) || (u_kind == 2);
            end
        end
    end

    // Scoreboard monitor: compare each SEND and each DONE/ERR against expectations
    always @(negedge SYSCLK) begin
        send_t s;
        out_t  o;
        if (!RESET) begin
            if (UART_SEND) begin
                chk("send_pending", 32'(exp_send.size() != 0), 32'd1);
                if (exp_send.size() != 0) begin
                    s = exp_send.pop_front();
                    chk("send_grant", 32'(GRANT), 32'(oh(s.idx)));
                    chk("send_data", 32'(UART_DATA), 32'(s.data));
                    chk("send_ack", 32'(REQ_ACK), 32'(oh(s.idx)));
                end
            end
            if ((REQ_DONE | REQ_ERR) != '0) begin
                chk("outcome_pending", 32'(exp_out.size() != 0), 32'd1);
                if (exp_out.size() != 0) begin
                    o = exp_out.pop_front();
                    chk("outcome_done", 32'(REQ_DONE), o.err ? 32'd0 : 32'(oh(o.idx)));
                    chk("outcome_err", 32'(REQ_ERR), o.err ? 32'(oh(o.idx)) : 32'd0);
                end
                if (REQ_ERR != '0) chk("err_release", 32'(GRANT), 32'd0);
            end
            if ((REQ_ACK | REQ_DONE | REQ_ERR) != '0)
                chk("pulse_onehot", 32'($onehot({REQ_ACK, REQ_DONE, REQ_ERR})), 32'd1);
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_send", 32'(UART_SEND), 32'd0);
        chk("rst_data", 32'(UART_DATA), 32'd0);
        chk("rst_tflag", 32'(TIMEOUT_FLAG), 32'd0);
        chk("rst_pulses", 32'({REQ_ACK, REQ_DONE, REQ_ERR}), 32'd0);
        do_reset();

        // Test 1: single byte from requester 2
        def_dly = 10;
        push_req(2, 8'hA5, 1'b1);
        exp_byte(2, 8'hA5, 1'b0);
        tick();
        chk("t1_grant", 32'(GRANT), 32'h4);
        chk("t1_send_early", 32'(UART_SEND), 32'd0);
        tick();
        chk("t1_send", 32'(UART_SEND), 32'd1);
        chk("t1_ack", 32'(REQ_ACK), 32'h4);
        drain("t1", 100);
        chk("t1_idle", 32'(GRANT), 32'd0);

        // Test 2: all four requesters, single-byte bursts, fair rotation
        do_reset();
        push_req(0, 8'h10, 1'b1); push_req(0, 8'h11, 1'b1);
        push_req(1, 8'h20, 1'b1); push_req(1, 8'h21, 1'b1);
        push_req(2, 8'h30, 1'b1);
        push_req(3, 8'h40, 1'b1);
        exp_byte(0, 8'h10, 1'b0); exp_byte(1, 8'h20, 1'b0);
        exp_byte(2, 8'h30, 1'b0); exp_byte(3, 8'h40, 1'b0);
        exp_byte(0, 8'h11, 1'b0); exp_byte(1, 8'h21, 1'b0);
        drain("t2", 400);

        // Test 3: MAX_BURST forced release lets requester 3 in
        do_reset();
        def_dly = 2;
        for (int k = 0; k < 20; k++) push_req(1, 8'(8'h60 + k), k == 19);
        for (int k = 0; k < 16; k++) exp_byte(1, 8'(8'h60 + k), 1'b0);
        exp_byte(3, 8'h90, 1'b0);
        for (int k = 16; k < 20; k++) exp_byte(1, 8'(8'h60 + k), 1'b0);
        tick(); tick(); tick();
        push_req(3, 8'h90, 1'b1);
        drain("t3", 600);

        // Test 4: error beats simultaneous complete on the 2nd byte
        do_reset();
        def_dly = 3;
        resp_q.push_back('{3, 0});
        resp_q.push_back('{3, 2});
        for (int k = 0; k < 5; k++) push_req(0, 8'(8'h80 + k), k == 4);
        push_req(1, 8'h50, 1'b1);
        exp_byte(0, 8'h80, 1'b0);
        exp_byte(0, 8'h81, 1'b1);
        exp_byte(1, 8'h50, 1'b0);
        for (int k = 2; k < 5; k++) exp_byte(0, 8'(8'h80 + k), 1'b0);
        drain("t4", 400);

        // Test 5: BUSY holds ISSUE, then the UART never answers
        do_reset();
        force_busy = 1'b1;
        resp_q.push_back('{1, 3});
        push_req(2, 8'hC3, 1'b1);
        exp_byte(2, 8'hC3, 1'b1);
        tick();
        chk("t5_grant", 32'(GRANT), 32'h4);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_busy_hold", 32'(UART_SEND), 32'd0);
        end
        force_busy = 1'b0;
        wait_send("t5");
        begin
            int n;
            n = 0;
            while (!TIMEOUT_FLAG && n < 200) begin
                tick();
                n++;
            end
            chk("t5_timeout_latency", 32'(n), 32'd100);
        end
        chk("t5_timeout_err", 32'(REQ_ERR), 32'h4);
        chk("t5_timeout_grant", 32'(GRANT), 32'd0);
        push_req(0, 8'h5A, 1'b1);
        exp_byte(0, 8'h5A, 1'b0);
        drain("t5", 100);
        chk("t5_tflag_sticky", 32'(TIMEOUT_FLAG), 32'd1);

        // Test 6: asynchronous reset during WAIT
        resp_q.push_back('{20, 0});
        push_req(1, 8'h77, 1'b1);
        begin
            send_t s;
            s.idx = 1; s.data = 8'h77;
            exp_send.push_back(s);
        end
        wait_send("t6");
        tick(); tick(); tick();
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(GRANT), 32'd0);
        chk("t6_rst_send", 32'(UART_SEND), 32'd0);
        chk("t6_rst_tflag", 32'(TIMEOUT_FLAG), 32'd0);
        chk("t6_rst_done", 32'(REQ_DONE), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            push_req(i, 8'(8'hE0 + i), 1'b1);
            exp_byte(i, 8'(8'hE0 + i), 1'b0);
        end
        tick(); tick();
        RESET = 1'b0;
        tick();
        chk("t6_first_grant", 32'(GRANT), 32'h1);
        drain("t6", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
